// File: rtl/pixel_mem_pkg.sv
// Shared owner encoding, default widths and read-tag codes for the pixel memory arbiter.
package pixel_mem_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VGA  = 2'd2
   } owner_e;

   localparam logic TAG_CPU = 1'b0;
   localparam logic TAG_VGA = 1'b1;

endpackage

// File: rtl/pixel_arb_wait_ctr.sv
// Saturating starvation counter: counts denied CPU cycles up to MAX_WAIT, clears on grant.
// Latency: count visible one cycle after the stall it records; no backpressure.
module pixel_arb_wait_ctr #(
   parameter int MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt
);

   localparam logic [3:0] LIM = 4'(MAX_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Arbitrates the single-port pixel memory between CPU str/ldr and VGA fetches (VGA priority).
// Latency: grant combinational, mem_* one cycle later, read data two cycles after grant.
// Backpressure: loser sees gnt=0 (cpu_stall); PIXEL_ARB_STARVE_GUARD_EN bounds CPU wait.
module pixel_mem_arbiter
   import pixel_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [3:0]        wait_cnt;
   logic              guard_win;
   owner_e            slot_q;
   logic              slot_rd;
   logic              tag_vld_q;
   logic              tag_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] vga_rdata_q;

`ifdef PIXEL_ARB_STARVE_GUARD_EN
   localparam logic GUARD_EN = 1'b1;

   pixel_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
      .clk (clk),
      .rst (rst),
      .inc (cpu_stall),
      .clr (cpu_gnt),
      .cnt (wait_cnt)
   );
`else
   localparam logic GUARD_EN = 1'b0;

   assign wait_cnt = '0;
`endif

   assign guard_win = GUARD_EN && (wait_cnt == 4'(MAX_WAIT));

   assign vga_gnt   = vga_req & ~(cpu_req & guard_win);
   assign cpu_gnt   = cpu_req & (~vga_req | guard_win);
   assign cpu_stall = cpu_req & ~cpu_gnt;

   // Slot register follows the winner; VGA leaves mem_wdata untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q    <= OWN_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else if (cpu_gnt) begin
         slot_q    <= OWN_CPU;
         mem_addr  <= cpu_addr;
         mem_wdata <= cpu_wdata;
         mem_we    <= cpu_we;
      end else if (vga_gnt) begin
         slot_q    <= OWN_VGA;
         mem_addr  <= vga_addr;
         mem_we    <= 1'b0;
      end else begin
         slot_q    <= OWN_IDLE;
         mem_we    <= 1'b0;
      end
   end

   // A CPU slot is a read exactly when the registered write enable is low.
   assign slot_rd = (slot_q == OWN_VGA) || ((slot_q == OWN_CPU) && !mem_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= 1'b0;
         tag_q     <= TAG_CPU;
      end else begin
         tag_vld_q <= slot_rd;
         tag_q     <= (slot_q == OWN_VGA) ? TAG_VGA : TAG_CPU;
      end
   end

   assign cpu_rvalid = tag_vld_q && (tag_q == TAG_CPU);
   assign vga_rvalid = tag_vld_q && (tag_q == TAG_VGA);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata_q <= '0;
         vga_rdata_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (vga_rvalid) vga_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed bench for pixel_mem_arbiter: stimulus pushes expected reads, a monitor pops them.
module tb_pixel_mem_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        vga_req;
   logic [15:0] vga_addr;
   logic        vga_gnt, vga_rvalid;
   logic [7:0]  vga_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = 8'h00;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [7:0] dat;
   } exp_t;

   exp_t exp_cpu[$];
   exp_t exp_vga[$];

   logic [7:0] pmem [0:65535];

   pixel_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAXW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_gnt    (vga_gnt),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port memory model.
   always @(posedge clk) begin
      if (mem_we) pmem[mem_addr] <= mem_wdata;
      mem_rdata <= pmem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cpu(input logic [7:0] d);
      exp_t e;
      e.cyc = cyc + 2;
      e.dat = d;
      exp_cpu.push_back(e);
   endtask

   task automatic push_vga(input logic [7:0] d);
      exp_t e;
      e.cyc = cyc + 2;
      e.dat = d;
      exp_vga.push_back(e);
   endtask

   // Monitor: every rvalid must match the head of its requester's queue.
   always @(negedge clk) begin
      exp_t e;
      chk("gnt_exclusive", {31'd0, cpu_gnt & vga_gnt}, 32'd0);
      if (cpu_rvalid) begin
         if (exp_cpu.size() == 0) begin
            chk("cpu_rvalid_unexpected", {31'd0, cpu_rvalid}, 32'd0);
         end else begin
            e = exp_cpu.pop_front();
            chk("cpu_rvalid_cycle", cyc, e.cyc);
            chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.dat});
         end
      end
      if (vga_rvalid) begin
         if (exp_vga.size() == 0) begin
            chk("vga_rvalid_unexpected", {31'd0, vga_rvalid}, 32'd0);
         end else begin
            e = exp_vga.pop_front();
            chk("vga_rvalid_cycle", cyc, e.cyc);
            chk("vga_rdata", {24'd0, vga_rdata}, {24'd0, e.dat});
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vga_req = 1'b0; vga_addr = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_mem_addr"},   {16'd0, mem_addr},  32'd0);
      chk({tag, "_mem_wdata"},  {24'd0, mem_wdata}, 32'd0);
      chk({tag, "_mem_we"},     {31'd0, mem_we},    32'd0);
      chk({tag, "_cpu_rdata"},  {24'd0, cpu_rdata}, 32'd0);
      chk({tag, "_vga_rdata"},  {24'd0, vga_rdata}, 32'd0);
      chk({tag, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
      chk({tag, "_vga_rvalid"}, {31'd0, vga_rvalid}, 32'd0);
   endtask

`ifdef PIXEL_ARB_STARVE_GUARD_EN
   task automatic starve_round();
      for (int k = 0; k <= MAXW; k++) begin
         next();
         vga_req = 1'b1; vga_addr = 16'h0200;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
         @(negedge clk);
         chk("starve_cpu_gnt", {31'd0, cpu_gnt}, (k == MAXW) ? 32'd1 : 32'd0);
         chk("starve_vga_gnt", {31'd0, vga_gnt}, (k == MAXW) ? 32'd0 : 32'd1);
         if (k == MAXW) push_cpu(8'h11);
         else           push_vga(8'h3C);
      end
      next();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("starve_wait_clr", {28'd0, dut.wait_cnt}, 32'd0);
      chk("starve_vga_back", {31'd0, vga_gnt}, 32'd1);
      push_vga(8'h3C);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) pmem[i] = 8'h00;
      pmem[16'h0200] = 8'h3C;
      pmem[16'h0001] = 8'h11;
      pmem[16'h0002] = 8'h22;

      rst = 1'b1;
      idle_inputs();
      repeat (3) next();
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");
      chk("reset_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("reset_vga_gnt", {31'd0, vga_gnt}, 32'd0);

      // Lone CPU write
      next();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
      @(negedge clk);
      chk("wr_cpu_gnt",   {31'd0, cpu_gnt},   32'd1);
      chk("wr_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("wr_vga_gnt",   {31'd0, vga_gnt},   32'd0);
      next();
      idle_inputs();
      @(negedge clk);
      chk("wr_mem_we",    {31'd0, mem_we},    32'd1);
      chk("wr_mem_addr",  {16'd0, mem_addr},  32'h0010);
      chk("wr_mem_wdata", {24'd0, mem_wdata}, 32'h00A5);
      repeat (2) next();

      // Lone VGA read
      vga_req = 1'b1; vga_addr = 16'h0200;
      @(negedge clk);
      chk("vr_vga_gnt", {31'd0, vga_gnt}, 32'd1);
      push_vga(8'h3C);
      next();
      idle_inputs();
      @(negedge clk);
      chk("vr_mem_we",    {31'd0, mem_we},    32'd0);
      chk("vr_mem_addr",  {16'd0, mem_addr},  32'h0200);
      chk("vr_mem_wdata", {24'd0, mem_wdata}, 32'h00A5);
      repeat (3) next();

      // Simultaneous requests: VGA wins, CPU follows once VGA drops
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
      vga_req = 1'b1; vga_addr = 16'h0002;
      @(negedge clk);
      chk("sim_vga_gnt",   {31'd0, vga_gnt},   32'd1);
      chk("sim_cpu_gnt",   {31'd0, cpu_gnt},   32'd0);
      chk("sim_cpu_stall", {31'd0, cpu_stall}, 32'd1);
      push_vga(8'h22);
      next();
      vga_req = 1'b0;
      @(negedge clk);
      chk("sim_cpu_gnt2", {31'd0, cpu_gnt}, 32'd1);
      push_cpu(8'h11);
      next();
      idle_inputs();
      repeat (3) next();

`ifdef PIXEL_ARB_STARVE_GUARD_EN
      starve_round();
      starve_round();
`else
      for (int k = 0; k < 8; k++) begin
         vga_req = 1'b1; vga_addr = 16'h0200;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
         @(negedge clk);
         chk("strict_cpu_gnt",   {31'd0, cpu_gnt},   32'd0);
         chk("strict_cpu_stall", {31'd0, cpu_stall}, 32'd1);
         push_vga(8'h3C);
         next();
      end
      vga_req = 1'b0;
      @(negedge clk);
      chk("strict_cpu_gnt_free", {31'd0, cpu_gnt}, 32'd1);
      push_cpu(8'h11);
`endif
      next();
      idle_inputs();
      repeat (3) next();

      // Interleaved CPU / VGA reads on back-to-back cycles
      for (int k = 0; k < 6; k++) begin
         idle_inputs();
         if (k % 2 == 0) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
         end else begin
            vga_req = 1'b1; vga_addr = 16'h0002;
         end
         @(negedge clk);
         if (k % 2 == 0) begin
            chk("il_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
            push_cpu(8'h11);
         end else begin
            chk("il_vga_gnt", {31'd0, vga_gnt}, 32'd1);
            push_vga(8'h22);
         end
         next();
      end
      idle_inputs();
      repeat (4) next();
      @(negedge clk);
      chk("hold_cpu_rdata", {24'd0, cpu_rdata}, 32'h0011);
      chk("hold_vga_rdata", {24'd0, vga_rdata}, 32'h0022);

      // Reset one cycle after a VGA grant: the read must vanish
      next();
      vga_req = 1'b1; vga_addr = 16'h0200;
      @(negedge clk);
      chk("rst_vga_gnt", {31'd0, vga_gnt}, 32'd1);
      next();
      idle_inputs();
      rst = 1'b1;
      next();
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      repeat (4) next();

      @(negedge clk);
      chk("cpu_queue_drained", exp_cpu.size(), 32'd0);
      chk("vga_queue_drained", exp_vga.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
